// File: rtl/sva_attempt_sched.sv
// Attempt scheduler for one synthesized SVA checker FSM: slot pool, shared evaluator, statistics.
// Optional age timeout enabled with `define SVA_SCHED_TIMEOUT_EN (adds timeout_cnt port).
module sva_attempt_sched #(
   parameter int NUM_SLOTS   = 8,
   parameter int STATE_W     = 8,
   parameter int START_STATE = 0,
   parameter int CNT_W       = 16,
   parameter int AGE_W       = 8,
   parameter int MAX_AGE     = 255
) (
   input  logic                         gclk,
   input  logic                         grst,
   input  logic                         tick,
   input  logic                         spawn_en,
   output logic                         busy,
   output logic                         done,
   output logic                         eval_req,
   output logic [$clog2(NUM_SLOTS)-1:0] eval_slot,
   output logic [STATE_W-1:0]           eval_state,
   output logic                         eval_is_new,
   input  logic                         eval_ack,
   input  logic [STATE_W-1:0]           eval_next_state,
   input  logic                         eval_next_active,
   input  logic                         eval_succ,
   input  logic                         eval_fail,
   output logic [$clog2(NUM_SLOTS):0]   active_cnt,
   output logic [CNT_W-1:0]             succ_cnt,
   output logic [CNT_W-1:0]             fail_cnt,
   output logic [CNT_W-1:0]             drop_cnt,
`ifdef SVA_SCHED_TIMEOUT_EN
   output logic [CNT_W-1:0]             timeout_cnt,
`endif
   output logic                         overflow,
   output logic                         overrun
);

   localparam int IDX_W = $clog2(NUM_SLOTS);
   localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

   // Age only matters up to MAX_AGE, so it saturates there (or at all-ones if smaller).
   localparam logic [AGE_W-1:0] AGE_SAT =
      (MAX_AGE >= (2**AGE_W) - 1) ? {AGE_W{1'b1}} : AGE_W'(MAX_AGE);

   typedef enum logic [2:0] {IDLE, SCAN, WAIT, SPAWN, WAIT_NEW, DONE} state_t;

   state_t               state;
   logic [NUM_SLOTS-1:0] slot_active;
   logic [NUM_SLOTS-1:0] scan_mask;
   logic [STATE_W-1:0]   slot_state [NUM_SLOTS];
   logic [AGE_W-1:0]     slot_age   [NUM_SLOTS];
   logic                 spawn_pend;

   logic                 scan_hit;
   logic [IDX_W-1:0]     scan_idx;
   logic                 free_hit;
   logic [IDX_W-1:0]     free_idx;
   logic                 res_fail;
   logic                 res_succ;
   logic                 res_live;
   logic [AGE_W-1:0]     age_next;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Lowest pending slot and lowest free slot; the downward loop leaves the lowest match.
   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      scan_hit = 1'b0;
      scan_idx = '0;
      free_hit = 1'b0;
      free_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (scan_mask[i]) begin
            scan_hit = 1'b1;
            scan_idx = IDX_W'(i);
         end
         if (!slot_active[i]) begin
            free_hit = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   // A terminal verdict overrides "continues"; fail outranks success.
   assign res_fail = eval_fail;
   assign res_succ = eval_succ & ~eval_fail;
   assign res_live = eval_next_active & ~eval_succ & ~eval_fail;
   assign age_next = (slot_age[eval_slot] >= AGE_SAT) ? AGE_SAT
                                                      : slot_age[eval_slot] + AGE_W'(1);

   always_ff @(posedge gclk or posedge grst) begin
      if (grst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         eval_req    <= 1'b0;
         eval_slot   <= '0;
         eval_state  <= '0;
         eval_is_new <= 1'b0;
         active_cnt  <= '0;
         succ_cnt    <= '0;
         fail_cnt    <= '0;
         drop_cnt    <= '0;
`ifdef SVA_SCHED_TIMEOUT_EN
         timeout_cnt <= '0;
`endif
         overflow    <= 1'b0;
         overrun     <= 1'b0;
         scan_mask   <= '0;
         spawn_pend  <= 1'b0;
         slot_active <= '0;
         // NOTE: the slot file is a handful of flops, not a RAM, so it is reset with the FSM.
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_state[i] <= '0;
            slot_age[i]   <= '0;
         end
      end else begin
         // NOTE: all state here uses <=, so every decision below sees pre-edge values.
         done <= 1'b0;
         if (tick && state != IDLE) overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (tick) begin
                  scan_mask  <= slot_active;
                  spawn_pend <= spawn_en;
                  busy       <= 1'b1;
                  state      <= SCAN;
               end
            end

            SCAN: begin
               if (!scan_hit) begin
                  state <= SPAWN;
               end
`ifdef SVA_SCHED_TIMEOUT_EN
               else if (slot_age[scan_idx] >= AGE_W'(MAX_AGE)) begin
                  slot_active[scan_idx] <= 1'b0;
                  scan_mask[scan_idx]   <= 1'b0;
                  active_cnt            <= active_cnt - CNT_ONE;
                  fail_cnt              <= sat_inc(fail_cnt);
                  timeout_cnt           <= sat_inc(timeout_cnt);
               end
`endif
               else begin
                  eval_req    <= 1'b1;
                  eval_slot   <= scan_idx;
                  eval_state  <= slot_state[scan_idx];
                  eval_is_new <= 1'b0;
                  state       <= WAIT;
               end
            end

            WAIT: begin
               if (eval_ack) begin
                  slot_state[eval_slot]  <= eval_next_state;
                  slot_active[eval_slot] <= res_live;
                  slot_age[eval_slot]    <= age_next;
                  if (!res_live) active_cnt <= active_cnt - CNT_ONE;
                  if (res_fail) fail_cnt <= sat_inc(fail_cnt);
                  if (res_succ) succ_cnt <= sat_inc(succ_cnt);
                  scan_mask[eval_slot] <= 1'b0;
                  eval_req             <= 1'b0;
                  state                <= SCAN;
               end
            end

            SPAWN: begin
               if (!spawn_pend) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else if (!free_hit) begin
                  overflow <= 1'b1;
                  drop_cnt <= sat_inc(drop_cnt);
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  eval_req    <= 1'b1;
                  eval_is_new <= 1'b1;
                  eval_state  <= STATE_W'(START_STATE);
                  eval_slot   <= free_idx;
                  state       <= WAIT_NEW;
               end
            end

            WAIT_NEW: begin
               if (eval_ack) begin
                  if (res_live) begin
                     slot_active[eval_slot] <= 1'b1;
                     slot_state[eval_slot]  <= eval_next_state;
                     slot_age[eval_slot]    <= AGE_W'(1);
                     active_cnt             <= active_cnt + CNT_ONE;
                  end
                  if (res_fail) fail_cnt <= sat_inc(fail_cnt);
                  if (res_succ) succ_cnt <= sat_inc(succ_cnt);
                  eval_req    <= 1'b0;
                  eval_is_new <= 1'b0;
                  done        <= 1'b1;
                  state       <= DONE;
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sva_attempt_sched.sv
// Scoreboard bench for sva_attempt_sched: a slot model predicts evaluator requests, round latency
// and statistics; a behavioural evaluator pops and checks each request. Honours SVA_SCHED_TIMEOUT_EN.
module tb_sva_attempt_sched;

   localparam int NUM_SLOTS = 8;
   localparam int STATE_W   = 8;
   localparam int CNT_W     = 16;
`ifdef SVA_SCHED_TIMEOUT_EN
   localparam int MAX_AGE   = 3;
`else
   localparam int MAX_AGE   = 255;
`endif

   logic                 gclk = 1'b0;
   logic                 grst = 1'b1;
   logic                 tick = 1'b0;
   logic                 spawn_en = 1'b0;
   logic                 busy, done, eval_req, eval_is_new;
   logic [2:0]           eval_slot;
   logic [STATE_W-1:0]   eval_state;
   logic                 eval_ack = 1'b0;
   logic [STATE_W-1:0]   eval_next_state = '0;
   logic                 eval_next_active = 1'b0;
   logic                 eval_succ = 1'b0;
   logic                 eval_fail = 1'b0;
   logic [3:0]           active_cnt;
   logic [CNT_W-1:0]     succ_cnt, fail_cnt, drop_cnt;
`ifdef SVA_SCHED_TIMEOUT_EN
   logic [CNT_W-1:0]     timeout_cnt;
`endif
   logic                 overflow, overrun;

   sva_attempt_sched #(
      .NUM_SLOTS(NUM_SLOTS), .STATE_W(STATE_W), .START_STATE(0),
      .CNT_W(CNT_W), .AGE_W(8), .MAX_AGE(MAX_AGE)
   ) dut (
      .gclk(gclk), .grst(grst), .tick(tick), .spawn_en(spawn_en),
      .busy(busy), .done(done), .eval_req(eval_req), .eval_slot(eval_slot),
      .eval_state(eval_state), .eval_is_new(eval_is_new), .eval_ack(eval_ack),
      .eval_next_state(eval_next_state), .eval_next_active(eval_next_active),
      .eval_succ(eval_succ), .eval_fail(eval_fail), .active_cnt(active_cnt),
      .succ_cnt(succ_cnt), .fail_cnt(fail_cnt), .drop_cnt(drop_cnt),
`ifdef SVA_SCHED_TIMEOUT_EN
      .timeout_cnt(timeout_cnt),
`endif
      .overflow(overflow), .overrun(overrun)
   );

   always #5 gclk = ~gclk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   typedef struct {
      int slot;
      int state;
      bit is_new;
   } req_t;
   req_t exp_q[$];

   // Reference model of the slot pool and statistics.
   bit [NUM_SLOTS-1:0] m_act = '0;
   int  m_state [NUM_SLOTS];
   int  m_age   [NUM_SLOTS];
   int  e_succ = 0, e_fail = 0, e_drop = 0, e_to = 0;
   bit  e_ovf = 0, e_ovr = 0;

   // Evaluator response tables for the current round.
   int  resp_ns   [NUM_SLOTS];
   bit  resp_act  [NUM_SLOTS];
   bit  resp_succ [NUM_SLOTS];
   bit  resp_fail [NUM_SLOTS];
   int  new_ns;
   bit  new_act, new_succ, new_fail;
   int  ack_delay = 0;
   bit  eval_en = 1'b1;
   bit  man_ack = 1'b0;

   bit   req_seen = 1'b0;
   int   wait_left = 0;
   int   held_slot, held_state;
   req_t cur;

   // Behavioural evaluator: checks each new request against the scoreboard, then acks.
   always @(negedge gclk) begin
      if (!eval_en) begin
         eval_ack         = man_ack;
         eval_next_state  = 8'd5;
         eval_next_active = 1'b1;
         eval_succ        = 1'b1;
         eval_fail        = 1'b0;
      end else begin
         eval_ack         = 1'b0;
         eval_next_state  = '0;
         eval_next_active = 1'b0;
         eval_succ        = 1'b0;
         eval_fail        = 1'b0;
         if (!eval_req) begin
            req_seen = 1'b0;
         end else begin
            if (!req_seen) begin
               req_seen   = 1'b1;
               wait_left  = ack_delay;
               held_slot  = int'(eval_slot);
               held_state = int'(eval_state);
               check("req_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  cur = exp_q.pop_front();
                  check("eval_slot", eval_slot, cur.slot);
                  check("eval_state", eval_state, cur.state);
                  check("eval_is_new", eval_is_new, cur.is_new);
               end
            end else begin
               check("hold_slot", eval_slot, held_slot);
               check("hold_state", eval_state, held_state);
            end
            if (wait_left == 0) begin
               eval_ack = 1'b1;
               if (eval_is_new) begin
                  eval_next_state  = STATE_W'(new_ns);
                  eval_next_active = new_act;
                  eval_succ        = new_succ;
                  eval_fail        = new_fail;
               end else begin
                  eval_next_state  = STATE_W'(resp_ns[eval_slot]);
                  eval_next_active = resp_act[eval_slot];
                  eval_succ        = resp_succ[eval_slot];
                  eval_fail        = resp_fail[eval_slot];
               end
               req_seen = 1'b0;
            end else begin
               wait_left--;
            end
         end
      end
   end

   task automatic set_resp(input int r);
      for (int i = 0; i < NUM_SLOTS; i++) begin
         resp_ns[i]   = (i * 7 + r * 3 + 1) % 120;
         resp_act[i]  = 1'b1;
         resp_succ[i] = 1'b0;
         resp_fail[i] = 1'b0;
      end
      new_ns   = (r * 5 + 2) % 120;
      new_act  = 1'b1;
      new_succ = 1'b0;
      new_fail = 1'b0;
   endtask

   // Predict one round: push expected requests, update the model, return edges from tick to DONE.
   task automatic plan_round(input bit sp, output int lat);
      bit   live;
      int   f;
      req_t r;
      lat = 0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (!m_act[i]) continue;
`ifdef SVA_SCHED_TIMEOUT_EN
         if (m_age[i] >= MAX_AGE) begin
            m_act[i] = 1'b0;
            e_fail++;
            e_to++;
            lat += 1;
            continue;
         end
`endif
         r.slot = i; r.state = m_state[i]; r.is_new = 1'b0;
         exp_q.push_back(r);
         live = resp_act[i] && !resp_succ[i] && !resp_fail[i];
         if (resp_fail[i]) e_fail++;
         else if (resp_succ[i]) e_succ++;
         m_act[i]   = live;
         m_state[i] = resp_ns[i];
         m_age[i]++;
         lat += 2 + ack_delay;
      end
      lat += 2;
      if (sp) begin
         f = -1;
         for (int i = NUM_SLOTS - 1; i >= 0; i--) if (!m_act[i]) f = i;
         if (f < 0) begin
            e_drop++;
            e_ovf = 1'b1;
         end else begin
            r.slot = f; r.state = 0; r.is_new = 1'b1;
            exp_q.push_back(r);
            if (new_fail) e_fail++;
            else if (new_succ) e_succ++;
            if (new_act && !new_succ && !new_fail) begin
               m_act[f]   = 1'b1;
               m_state[f] = new_ns;
               m_age[f]   = 1;
            end
            lat += 1 + ack_delay;
         end
      end
   endtask

   task automatic check_stats();
      check("active_cnt", active_cnt, $countones(m_act));
      check("succ_cnt", succ_cnt, e_succ);
      check("fail_cnt", fail_cnt, e_fail);
      check("drop_cnt", drop_cnt, e_drop);
      check("overflow", overflow, e_ovf);
      check("overrun", overrun, e_ovr);
`ifdef SVA_SCHED_TIMEOUT_EN
      check("timeout_cnt", timeout_cnt, e_to);
`endif
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_busy"}, busy, 0);
      check({pfx, "_done"}, done, 0);
      check({pfx, "_eval_req"}, eval_req, 0);
      check({pfx, "_eval_slot"}, eval_slot, 0);
      check({pfx, "_eval_state"}, eval_state, 0);
      check({pfx, "_eval_is_new"}, eval_is_new, 0);
      check({pfx, "_active_cnt"}, active_cnt, 0);
      check({pfx, "_succ_cnt"}, succ_cnt, 0);
      check({pfx, "_fail_cnt"}, fail_cnt, 0);
      check({pfx, "_drop_cnt"}, drop_cnt, 0);
      check({pfx, "_overflow"}, overflow, 0);
      check({pfx, "_overrun"}, overrun, 0);
`ifdef SVA_SCHED_TIMEOUT_EN
      check({pfx, "_timeout_cnt"}, timeout_cnt, 0);
`endif
   endtask

   // One evaluation round; ovr_at != 0 re-pulses tick that many negedges into the round.
   task automatic run_round(input bit sp, input int ovr_at);
      int lat;
      int n;
      bit got;
      plan_round(sp, lat);
      @(negedge gclk);
      tick     = 1'b1;
      spawn_en = sp;
      n   = 0;
      got = 1'b0;
      while (!got && n < lat + 40) begin
         @(negedge gclk);
         n++;
         tick     = (ovr_at != 0 && n == ovr_at);
         spawn_en = 1'b0;
         if (tick) e_ovr = 1'b1;
         got = done;
      end
      tick = 1'b0;
      check("done_seen", got, 1);
      check("done_edges", n - 1, lat);
      @(negedge gclk);
      check("done_width", done, 0);
      check("busy_after", busy, 0);
      check("q_drained", exp_q.size(), 0);
      exp_q.delete();
      check_stats();
   endtask

   initial begin
      int n;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         m_state[i] = 0;
         m_age[i]   = 0;
      end
      repeat (3) @(negedge gclk);
      check_zero("rst");
      grst = 1'b0;

      // First spawn from an empty pool.
      set_resp(1);
      run_round(1'b1, 0);
      for (int r = 2; r <= 6; r++) begin
         set_resp(r);
         run_round(1'b1, 0);
      end

      // Quietly retire 1, 3, 4 to leave slots 0, 2, 5; then slot 2 succeeds.
      set_resp(7);
      resp_act[1] = 1'b0;
      resp_act[3] = 1'b0;
      resp_act[4] = 1'b0;
      run_round(1'b0, 0);
      set_resp(8);
      resp_succ[2] = 1'b1;
      run_round(1'b0, 0);

      // Fill the pool, then two spawns that must be dropped.
      for (int r = 9; r <= 16; r++) begin
         set_resp(r);
         run_round(1'b1, 0);
      end

      // Both verdicts at once, with a slow evaluator.
      set_resp(17);
      resp_succ[3] = 1'b1;
      resp_fail[3] = 1'b1;
      ack_delay = 4;
      run_round(1'b0, 0);

      // Tick while busy.
      set_resp(18);
      ack_delay = 2;
      run_round(1'b1, 3);
      ack_delay = 0;

      // Reset while a request is pending, then a stray ack.
      eval_en = 1'b0;
      @(negedge gclk);
      tick = 1'b1;
      @(negedge gclk);
      tick = 1'b0;
      n = 0;
      while (!eval_req && n < 20) begin
         @(negedge gclk);
         n++;
      end
      check("req_before_rst", eval_req, 1);
      grst = 1'b1;
      @(negedge gclk);
      check_zero("abort");
      grst = 1'b0;
      man_ack = 1'b1;
      repeat (2) @(negedge gclk);
      man_ack = 1'b0;
      repeat (2) @(negedge gclk);
      check_zero("late_ack");
      eval_en = 1'b1;
      m_act = '0;
      e_succ = 0; e_fail = 0; e_drop = 0; e_to = 0;
      e_ovf = 1'b0; e_ovr = 1'b0;

      set_resp(20);
      run_round(1'b1, 0);
`ifdef SVA_SCHED_TIMEOUT_EN
      for (int r = 21; r <= 23; r++) begin
         set_resp(r);
         run_round(1'b0, 0);
      end
      check("to_timeout_cnt", timeout_cnt, 1);
      check("to_fail_cnt", fail_cnt, 1);
      check("to_active_cnt", active_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish before 500000");
      $fatal(1, "watchdog expired");
   end

endmodule
